// File: rtl/alu_core.sv
// alu_core: responder side of the CPU/ALU SPR link. Single-cycle logic and
// arithmetic plus 32-cycle shift-add multiply and restoring divide.
//
// Ports:
//   i_clk, i_rst_n          clock (rising edge), async active-low reset
//   i_input_op, i_data_valid, i_data
//                           push side: 0=A, 1=B, 2=start(opcode), 3=clear
//   i_output_op             pop-side read select: 0=Y, 1=H, 2=A, 3=flags
//   i_result_empty          CPU consumes the current result
//   o_result_valid          unconsumed result held
//   o_result                combinational register readback
//   o_result_flags          {E,V,C,N,Z}
module alu_core #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [1:0]       i_input_op,
    input  logic             i_data_valid,
    input  logic [WIDTH-1:0] i_data,
    input  logic [1:0]       i_output_op,
    input  logic             i_result_empty,
    output logic             o_result_valid,
    output logic [WIDTH-1:0] o_result,
    output logic [4:0]       o_result_flags
);

    localparam int W  = WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV
    } state_t;

    state_t        state;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  y_q;
    logic [W-1:0]  h_q;
    logic [4:0]    flags_q;
    logic          valid_q;
    logic [CW-1:0] cnt;

    // Working registers: wm = multiplicand/divisor, wq = multiplier/quotient,
    // wr = product high half / partial remainder.
    logic [W-1:0]  wm;
    logic [W-1:0]  wq;
    logic [W-1:0]  wr;

    logic          cmd_wa;
    logic          cmd_wb;
    logic          cmd_start;
    logic          cmd_clr;
    logic [3:0]    opc;

    assign cmd_wa    = i_data_valid && (i_input_op == 2'd0);
    assign cmd_wb    = i_data_valid && (i_input_op == 2'd1);
    assign cmd_start = i_data_valid && (i_input_op == 2'd2);
    assign cmd_clr   = i_data_valid && (i_input_op == 2'd3);
    assign opc       = i_data[3:0];

    // Single-cycle datapath
    logic [W:0]    sum33;
    logic [W:0]    dif33;
    logic [W:0]    shl33;
    logic [W:0]    shr33;
    logic [W:0]    sar33;
    logic [4:0]    shamt;
    logic [W-1:0]  sc_y;
    logic [W-1:0]  sc_h;
    logic          sc_c;
    logic          sc_v;
    logic          sc_e;
    logic [4:0]    sc_flags;

    assign shamt = b_q[4:0];
    assign sum33 = {1'b0, a_q} + {1'b0, b_q};
    assign dif33 = {1'b0, a_q} - {1'b0, b_q};
    // The extra bit catches the last bit shifted out (zero for amount 0).
    assign shl33 = {1'b0, a_q} << shamt;
    assign shr33 = {a_q, 1'b0} >> shamt;
    assign sar33 = $signed({a_q, 1'b0}) >>> shamt;

    always_comb begin
        sc_y = '0;
        sc_h = '0;
        sc_c = 1'b0;
        sc_v = 1'b0;
        sc_e = 1'b0;
        case (opc)
            4'd0: begin
                sc_y = sum33[W-1:0];
                sc_c = sum33[W];
                sc_v = (a_q[W-1] == b_q[W-1]) && (sc_y[W-1] != a_q[W-1]);
            end
            4'd1: begin
                sc_y = dif33[W-1:0];
                sc_c = dif33[W];
                sc_v = (a_q[W-1] != b_q[W-1]) && (sc_y[W-1] != a_q[W-1]);
            end
            4'd2: sc_y = a_q & b_q;
            4'd3: sc_y = a_q | b_q;
            4'd4: sc_y = a_q ^ b_q;
            4'd5: begin
                sc_y = shl33[W-1:0];
                sc_c = shl33[W];
            end
            4'd6: begin
                sc_y = shr33[W:1];
                sc_c = shr33[0];
            end
            4'd7: begin
                sc_y = sar33[W:1];
                sc_c = sar33[0];
            end
            // Only reached with B == 0; a non-zero divisor iterates instead.
            4'd9: begin
                sc_y = '1;
                sc_h = a_q;
                sc_e = 1'b1;
            end
            default: sc_e = 1'b1;
        endcase
        sc_flags = {sc_e, sc_v, sc_c,
                    !opc[3] && sc_y[W-1],
                    !opc[3] && (sc_y == '0)};
    end

    // One multiply step: conditionally add, then shift {acc,multiplier} right.
    logic [W:0]    add33;
    logic [W-1:0]  mul_r;
    logic [W-1:0]  mul_q;

    assign add33 = wq[0] ? ({1'b0, wr} + {1'b0, wm}) : {1'b0, wr};
    assign mul_r = add33[W:1];
    assign mul_q = {add33[0], wq[W-1:1]};

    // One restoring divide step; trial[W] set means the subtract went negative.
    logic [W:0]    sh33;
    logic [W:0]    trial;
    logic          ge;
    logic [W-1:0]  div_r;
    logic [W-1:0]  div_q;

    assign sh33  = {wr, wq[W-1]};
    assign trial = sh33 - {1'b0, wm};
    assign ge    = !trial[W];
    assign div_r = ge ? trial[W-1:0] : sh33[W-1:0];
    assign div_q = {wq[W-2:0], ge};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            y_q     <= '0;
            h_q     <= '0;
            flags_q <= '0;
            valid_q <= 1'b0;
            cnt     <= '0;
            wm      <= '0;
            wq      <= '0;
            wr      <= '0;
        end else if (cmd_clr) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            y_q     <= '0;
            h_q     <= '0;
            flags_q <= '0;
            valid_q <= 1'b0;
            cnt     <= '0;
            wm      <= '0;
            wq      <= '0;
            wr      <= '0;
        end else begin
            if (cmd_wa) a_q <= i_data;
            if (cmd_wb) b_q <= i_data;
            case (state)
                IDLE: begin
                    if (cmd_start) begin
                        valid_q <= 1'b0;
                        cnt     <= '0;
                        if (opc == 4'd8) begin
                            state <= MUL;
                            wm    <= a_q;
                            wq    <= b_q;
                            wr    <= '0;
                        end else if (opc == 4'd9 && b_q != '0) begin
                            state <= DIV;
                            wm    <= b_q;
                            wq    <= a_q;
                            wr    <= '0;
                        end else begin
                            y_q     <= sc_y;
                            h_q     <= sc_h;
                            flags_q <= sc_flags;
                            valid_q <= 1'b1;
                        end
                    end else if (i_result_empty && valid_q) begin
                        valid_q <= 1'b0;
                    end
                end
                MUL: begin
                    wr  <= mul_r;
                    wq  <= mul_q;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        y_q     <= mul_q;
                        h_q     <= mul_r;
                        flags_q <= {2'b00, mul_r != '0, mul_r[W-1],
                                    {mul_r, mul_q} == '0};
                        valid_q <= 1'b1;
                        state   <= IDLE;
                    end
                end
                DIV: begin
                    wr  <= div_r;
                    wq  <= div_q;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        y_q     <= div_q;
                        h_q     <= div_r;
                        flags_q <= {4'b0000, div_q == '0};
                        valid_q <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        case (i_output_op)
            2'd0:    o_result = y_q;
            2'd1:    o_result = h_q;
            2'd2:    o_result = a_q;
            default: o_result = {{(W-5){1'b0}}, flags_q};
        endcase
    end

    assign o_result_valid = valid_q;
    assign o_result_flags = flags_q;

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: randomized and directed checks of alu_core against an
// arithmetic reference model.
module tb_alu_core;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [1:0]  i_input_op = 2'd0;
    logic        i_data_valid = 1'b0;
    logic [31:0] i_data = '0;
    logic [1:0]  i_output_op = 2'd0;
    logic        i_result_empty = 1'b0;
    logic        o_result_valid;
    logic [31:0] o_result;
    logic [4:0]  o_result_flags;

    alu_core #(.WIDTH(32)) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_input_op     (i_input_op),
        .i_data_valid   (i_data_valid),
        .i_data         (i_data),
        .i_output_op    (i_output_op),
        .i_result_empty (i_result_empty),
        .o_result_valid (o_result_valid),
        .o_result       (o_result),
        .o_result_flags (o_result_flags)
    );

    always #5 i_clk = ~i_clk;

    int vecs = 0;
    int miscmp = 0;

    // Expected architectural state
    logic [31:0] ma = '0;
    logic [31:0] mb = '0;
    logic [31:0] my = '0;
    logic [31:0] mh = '0;
    logic [4:0]  mf = '0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            miscmp++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] sel, output logic [31:0] v);
        i_output_op = sel;
        #1;
        v = o_result;
    endtask

    task automatic wr(input logic [1:0] op, input logic [31:0] d);
        i_input_op   = op;
        i_data       = d;
        i_data_valid = 1'b1;
        tick();
        i_data_valid = 1'b0;
    endtask

    task automatic start(input logic [3:0] opc);
        wr(2'd2, {28'b0, opc});
    endtask

    // Reference: results from plain integer arithmetic on the operands.
    task automatic ref_op(input logic [3:0] opc, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] y,
                          output logic [31:0] h, output logic [4:0] f,
                          output int lat);
        logic z, n, c, v, e;
        longint sa;
        logic [63:0] p;
        int s;
        z = 0; n = 0; c = 0; v = 0; e = 0;
        y = '0; h = '0; lat = 0;
        s = int'(b[4:0]);
        case (opc)
            4'd0: begin
                p = {32'b0, a} + {32'b0, b};
                y = p[31:0];
                c = p[32];
                sa = longint'($signed(a)) + longint'($signed(b));
                v = (sa > 64'sd2147483647) || (sa < -64'sd2147483648);
            end
            4'd1: begin
                y = a - b;
                c = (a < b);
                sa = longint'($signed(a)) - longint'($signed(b));
                v = (sa > 64'sd2147483647) || (sa < -64'sd2147483648);
            end
            4'd2: y = a & b;
            4'd3: y = a | b;
            4'd4: y = a ^ b;
            4'd5: begin
                y = a << s;
                c = (s != 0) ? a[32-s] : 1'b0;
            end
            4'd6: begin
                y = a >> s;
                c = (s != 0) ? a[s-1] : 1'b0;
            end
            4'd7: begin
                y = $signed(a) >>> s;
                c = (s != 0) ? a[s-1] : 1'b0;
            end
            4'd8: begin
                p = {32'b0, a} * {32'b0, b};
                y = p[31:0];
                h = p[63:32];
                lat = 32;
            end
            4'd9: begin
                if (b == 0) begin
                    y = 32'hFFFF_FFFF;
                    h = a;
                    e = 1;
                end else begin
                    y = a / b;
                    h = a % b;
                    z = (y == 0);
                    lat = 32;
                end
            end
            default: e = 1;
        endcase
        if (opc < 4'd8) begin
            z = (y == 0);
            n = y[31];
        end
        if (opc == 4'd8) begin
            z = ({h, y} == 64'd0);
            n = h[31];
            c = (h != 0);
        end
        f = {e, v, c, n, z};
    endtask

    // mode 1: write A mid-iteration; mode 2: issue a start while busy.
    task automatic do_op(input logic [3:0] opc, input string tag,
                         input int mode);
        logic [31:0] ey, eh, v;
        logic [4:0]  ef;
        int lat, n;
        ref_op(opc, ma, mb, ey, eh, ef, lat);
        start(opc);
        n = 0;
        while (!o_result_valid && n < 40) begin
            if (n == 5) begin
                rd(2'd0, v);
                chk({tag, " stale Y"}, v, my);
                rd(2'd1, v);
                chk({tag, " stale H"}, v, mh);
            end
            if (mode == 1 && n == 10) begin
                wr(2'd0, 32'd5);
                ma = 32'd5;
            end else if (mode == 2 && n == 12) begin
                start(4'd0);
            end else begin
                tick();
            end
            n++;
        end
        chk({tag, " latency"}, 32'(n), 32'(lat));
        my = ey;
        mh = eh;
        mf = ef;
        rd(2'd0, v);
        chk({tag, " Y"}, v, ey);
        rd(2'd1, v);
        chk({tag, " H"}, v, eh);
        chk({tag, " flags"}, 32'(o_result_flags), 32'(ef));
    endtask

    task automatic pop(input string tag);
        logic [31:0] v;
        i_result_empty = 1'b1;
        tick();
        i_result_empty = 1'b0;
        chk({tag, " pop valid"}, 32'(o_result_valid), 32'd0);
        rd(2'd0, v);
        chk({tag, " pop Y kept"}, v, my);
    endtask

    task automatic set_ab(input logic [31:0] a, input logic [31:0] b);
        wr(2'd0, a);
        wr(2'd1, b);
        ma = a;
        mb = b;
    endtask

    initial begin
        logic [31:0] v, ey, eh;
        logic [4:0]  ef;
        logic [3:0]  opc;
        int lat;

        // Reset state
        #1;
        chk("rst valid", 32'(o_result_valid), 32'd0);
        chk("rst flags", 32'(o_result_flags), 32'd0);
        rd(2'd0, v); chk("rst Y", v, 32'd0);
        rd(2'd1, v); chk("rst H", v, 32'd0);
        rd(2'd2, v); chk("rst A", v, 32'd0);
        #7 i_rst_n = 1'b1;

        // ADD overflow, then pop
        set_ab(32'h7FFF_FFFF, 32'd1);
        do_op(4'd0, "add ovf", 0);
        chk("add ovf Y const", my, 32'h8000_0000);
        chk("add ovf NV", 32'(o_result_flags), 32'h0A);
        pop("add ovf");

        // MULU all-ones with a mid-iteration A write
        set_ab(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op(4'd8, "mul ff", 1);
        chk("mul ff Y const", my, 32'd1);
        chk("mul ff H const", mh, 32'hFFFF_FFFE);
        rd(2'd2, v); chk("mul ff A readback", v, 32'd5);

        // DIVU and divide by zero
        set_ab(32'd100, 32'd7);
        do_op(4'd9, "div 100/7", 0);
        chk("div Y const", my, 32'd14);
        chk("div H const", mh, 32'd2);
        set_ab(32'd100, 32'd0);
        do_op(4'd9, "div0", 0);
        chk("div0 flags const", 32'(o_result_flags), 32'h10);

        // Shift by B=33 (amount 1), illegal opcode
        set_ab(32'h8000_0001, 32'd33);
        do_op(4'd5, "shl33", 0);
        chk("shl33 Y const", my, 32'd2);
        do_op(4'd12, "op12", 0);
        chk("op12 flags const", 32'(o_result_flags), 32'h10);

        // Start while busy is ignored
        set_ab(32'h1234_5678, 32'h9ABC_DEF0);
        do_op(4'd8, "mul busy", 2);

        // Reset at MUL iteration 10
        set_ab(32'd3, 32'd9);
        start(4'd8);
        repeat (10) tick();
        #2 i_rst_n = 1'b0;
        #1;
        chk("rst mid valid", 32'(o_result_valid), 32'd0);
        chk("rst mid flags", 32'(o_result_flags), 32'd0);
        rd(2'd0, v); chk("rst mid Y", v, 32'd0);
        rd(2'd1, v); chk("rst mid H", v, 32'd0);
        #1 i_rst_n = 1'b1;
        ma = '0; mb = '0; my = '0; mh = '0; mf = '0;
        set_ab(32'd40000, 32'd70000);
        do_op(4'd8, "mul after rst", 0);

        // Clear at MUL iteration 5
        set_ab(32'hDEAD_BEEF, 32'h0000_1001);
        start(4'd8);
        repeat (5) tick();
        wr(2'd3, 32'd0);
        ma = '0; mb = '0; my = '0; mh = '0; mf = '0;
        chk("clr valid", 32'(o_result_valid), 32'd0);
        chk("clr flags", 32'(o_result_flags), 32'd0);
        rd(2'd2, v); chk("clr A", v, 32'd0);
        rd(2'd0, v); chk("clr Y", v, 32'd0);
        rd(2'd1, v); chk("clr H", v, 32'd0);
        repeat (35) tick();
        chk("clr aborted", 32'(o_result_valid), 32'd0);
        do_op(4'd0, "add after clr", 0);

        // Start and pop in the same cycle
        set_ab(32'd3, 32'd4);
        do_op(4'd0, "sp add", 0);
        ref_op(4'd1, ma, mb, ey, eh, ef, lat);
        i_result_empty = 1'b1;
        start(4'd1);
        i_result_empty = 1'b0;
        my = ey; mh = eh; mf = ef;
        chk("sp valid", 32'(o_result_valid), 32'd1);
        rd(2'd0, v); chk("sp Y", v, ey);
        chk("sp flags", 32'(o_result_flags), 32'(ef));

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            i_input_op = 2'($urandom_range(0, 3));
            i_data = $urandom;
            tick();
            set_ab($urandom,
                   ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40))
                                               : $urandom);
            if ($urandom_range(0, 4) == 0)
                opc = 4'($urandom_range(10, 15));
            else
                opc = 4'($urandom_range(0, 9));
            do_op(opc, $sformatf("rnd%0d op%0d", i, opc), 0);
            if ($urandom_range(0, 1) == 1) pop($sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
        $finish;
    end

endmodule

// File: doc/alu_core.md
Name: alu_core

Overview:
- Responder end of the CPU↔ALU SPR interface. The CPU pushes operands and an opcode through input ops, then pops results through output ops.
- Executes single-cycle logic/arithmetic and 32-cycle iterative unsigned multiply/divide.
- Holds a result-valid flag until the CPU consumes the result. While valid is high, the CPU latches the flags into STATUS each cycle.

Parameters:
- WIDTH, 32, operand/result width. Only 32 is supported; iteration count equals WIDTH.

Ports:
- i_clk  input  1  clock, rising edge
- i_rst_n  input  1  reset, asynchronous, active-low
- i_input_op  input  2  0=write A, 1=write B, 2=start (opcode in i_data[3:0]), 3=clear
- i_data_valid  input  1  qualifies i_input_op/i_data for this cycle
- i_data  input  32  operand or opcode
- i_output_op  input  2  0=Y (result low), 1=H (result high/remainder), 2=A readback, 3={27'b0,flags}
- i_result_empty  input  1  pop: CPU consumes the current result this cycle
- o_result_valid  output  1  result registers hold an unconsumed result
- o_result  output  32  combinational mux of registers selected by i_output_op, valid or not
- o_result_flags  output  5  [0]Z [1]N [2]C [3]V [4]E (error)

Behaviour:
- Reset (async, i_rst_n low):
  - A, B, Y, H, flags, working regs = 0.
  - state = IDLE; o_result_valid = 0; o_result_flags = 0.
- States: IDLE, MUL, DIV. Busy means state != IDLE.
- Writes A/B (op 0/1 with i_data_valid): accepted in any state, effective next edge. They never affect an in-flight MUL/DIV, because operands are copied to working regs at start.
- Start (op 2) in IDLE:
  - o_result_valid cleared at the start edge.
  - Single-cycle opcodes write Y/H/flags at that edge; o_result_valid = 1 from the next cycle.
- Start while busy: ignored; no state change.
- Clear (op 3), any state: next edge → IDLE; A, B, Y, H, flags, valid = 0. An in-flight op is aborted.
- Opcodes:
  - 0 ADD: Y=A+B, C=carry out, V=signed overflow.
  - 1 SUB: Y=A-B, C=borrow (A<B unsigned), V=signed overflow.
  - 2 AND, 3 OR, 4 XOR: C=V=0.
  - 5 SHL, 6 SHR (logical), 7 SAR: shift amount B[4:0]; C=last bit shifted out (0 if amount 0); V=0.
  - For opcodes 0-7: H=0; Z=(Y==0); N=Y[31].
  - 8 MULU: shift-add, one bit per cycle, 32 cycles in MUL. {H,Y}=A*B. Z=({H,Y}==0), N=H[31], C=(H!=0), V=0.
  - 9 DIVU: restoring division, one bit per cycle, 32 cycles in DIV. Y=quotient, H=remainder. Z=(Y==0), N=C=V=0.
  - DIVU with B==0: no iteration, completes as single-cycle. Y=32'hFFFFFFFF, H=A, E=1, other flags 0.
  - Opcodes 10-15: single-cycle; Y=H=0, E=1, other flags 0.
  - E=0 for every legal, non-faulting op.
- Multi-cycle latency:
  - Start accepted at edge k; iterations run on edges k+1..k+32.
  - Y/H/flags written and valid set at edge k+32, so o_result_valid is visible from cycle k+32.
  - Y/H/flags keep their old values until completion.
- Pop (i_result_empty) while valid and no start/clear in the same cycle: o_result_valid = 0 at next edge; Y/H/flags retained.
- Pop while not valid, or while busy: ignored.
- Simultaneous start + pop: start wins. The pop consumes the old result; valid follows the new op's latency.
- Simultaneous clear + anything: clear wins.
- i_data_valid low: i_input_op ignored entirely.
- o_result is purely combinational from registers. Reading while busy returns stale Y/H.

Test Plan:
- Reset mid-MUL (assert i_rst_n low at iteration 10) → all outputs 0 immediately; IDLE; fresh MUL after release gives correct result.
- A=32'h7FFFFFFF, B=1, start ADD → next cycle valid=1, Y=32'h80000000, flags N=1,V=1,Z=0,C=0. Pop → valid=0 next cycle, Y retained.
- A=32'hFFFFFFFF, B=32'hFFFFFFFF, start MULU at edge k → valid low through cycle k+31, high at k+32; Y=1, H=32'hFFFFFFFE, C=1. Write A=5 during iterations → result unchanged.
- A=100, B=7, start DIVU → after 32 cycles Y=14, H=2. Then B=0, start DIVU → next cycle Y=32'hFFFFFFFF, H=100, E=1.
- Start SHL with B=33 (amount 1), A=32'h80000001 → Y=2, C=1. Start opcode 12 → Y=0, E=1. Start during MUL busy → ignored; MUL result intact.
- Clear at MUL iteration 5 → IDLE next cycle, valid=0, A=B=Y=H=0. Start+pop same cycle on a valid ADD result → new result valid next cycle.
